// File: rtl/cpu16_ctrl_pkg.sv
// Shared encodings for the cpu16 main control FSM and the downstream ALU control.
// Latency: n/a (constants, types and a pure decode function only).
// Backpressure: n/a.
package cpu16_ctrl_pkg;

  // IR[15:12] opcodes; codes 8..15 are illegal
  localparam logic [3:0] OP_R    = 4'd0;
  localparam logic [3:0] OP_ADDI = 4'd1;
  localparam logic [3:0] OP_ORI  = 4'd2;
  localparam logic [3:0] OP_LW   = 4'd3;
  localparam logic [3:0] OP_SW   = 4'd4;
  localparam logic [3:0] OP_BEQ  = 4'd5;
  localparam logic [3:0] OP_BNE  = 4'd6;
  localparam logic [3:0] OP_J    = 4'd7;

  // alu_op codes, decoded further by ALU control
  localparam logic [1:0] ALU_ADD  = 2'd0;
  localparam logic [1:0] ALU_SUB  = 2'd1;
  localparam logic [1:0] ALU_FUNC = 2'd2;
  localparam logic [1:0] ALU_OR   = 2'd3;

  // ALU B-operand select
  localparam logic [1:0] SRCB_B      = 2'd0;
  localparam logic [1:0] SRCB_TWO    = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  // PC source select
  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  typedef enum logic [3:0] {
    S_RST      = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_ALU_WB   = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WB   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  // Datapath control word (Moore part only)
  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  // States that wait on mem_ready and therefore run the bus timer
  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

  // Moore control word for a state; opcode only matters once it is stable (post-DECODE)
  function automatic ctrl_t moore_ctrl(input state_t s, input logic [3:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_TWO;
        c.alu_op    = ALU_ADD;
        c.pc_src    = PC_ALU;
      end
      S_DECODE: c.alu_src_b = SRCB_IMM_SH;
      S_EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_B;
        c.alu_op    = ALU_FUNC;
      end
      S_EXEC_I: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = (op == OP_ORI) ? ALU_OR : ALU_ADD;
      end
      S_ALU_WB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = (op == OP_R);
      end
      S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_B;
        c.alu_op    = ALU_SUB;
        c.pc_src    = PC_ALUOUT;
      end
      S_JUMP: begin
        c.pc_write = 1'b1;
        c.pc_src   = PC_JUMP;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ctrl_wait_timer.sv
// Bounded memory-wait timer: counts stalled cycles, flags the WAIT_MAX-th consecutive stall.
// Latency: expired is combinational from the count and stall in the same cycle.
// Backpressure: none; clear has priority over counting.
// Ports: clk, reset (sync, high), clear (zero the count), stall (count this cycle), expired.
module ctrl_wait_timer #(
  parameter int WAIT_MAX = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic stall,
  output logic expired
);

  localparam int CW = $clog2(WAIT_MAX);

  logic [CW-1:0] r_cnt;

  // Count WAIT_MAX-1 means this is the WAIT_MAX-th stalled cycle
  assign expired = stall && (r_cnt == CW'(WAIT_MAX - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_cnt <= '0;
    end else if (stall) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/main_control_fsm.sv
// Multi-cycle main control of the cpu16: fetch/decode/execute/memory/writeback sequencing.
// Latency: R/I 4, lw 5, sw 4, branch/jump 3 cycles with mem_ready high; memory states stall on it.
// Backpressure: FETCH/MEM_RD/MEM_WR hold for mem_ready, bounded by WAIT_MAX then bus_err.
// Ports: clk, reset, opcode, zero, mem_ready in; datapath enables, alu_op, illegal_op,
//        bus_err and state_o out. ir_write, pc_write (FETCH/BRANCH), illegal_op, bus_err are Mealy.
module main_control_fsm
  import cpu16_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       illegal_op,
  output logic       bus_err,
  output logic [3:0] state_o
);

  state_t r_state;
  ctrl_t  r_ctrl;
  state_t w_next;
  logic   w_in_wait, w_stall, w_clear, w_expired;
  logic   w_fetch_ok, w_br_take;

  assign w_in_wait = is_wait_state(r_state);
  assign w_stall   = w_in_wait && !mem_ready;
  // Count restarts on every state entry and after a timeout (FETCH re-enters itself then)
  assign w_clear   = !w_in_wait || (w_next != r_state) || w_expired;

  ctrl_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_clear),
    .stall   (w_stall),
    .expired (w_expired)
  );

  always_comb begin
    w_next = S_RST;
    case (r_state)
      S_RST:    w_next = S_FETCH;
      S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_R:            w_next = S_EXEC_R;
          OP_ADDI, OP_ORI: w_next = S_EXEC_I;
          OP_LW, OP_SW:    w_next = S_MEM_ADDR;
          OP_BEQ, OP_BNE:  w_next = S_BRANCH;
          OP_J:            w_next = S_JUMP;
          default:         w_next = S_FETCH;
        endcase
      end
      S_EXEC_R, S_EXEC_I: w_next = S_ALU_WB;
      S_MEM_ADDR: w_next = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      // mem_ready beats the timeout when both land in the same cycle
      S_MEM_RD:   w_next = mem_ready ? S_MEM_WB : (w_expired ? S_FETCH : S_MEM_RD);
      S_MEM_WR:   w_next = (mem_ready || w_expired) ? S_FETCH : S_MEM_WR;
      S_ALU_WB, S_MEM_WB, S_BRANCH, S_JUMP: w_next = S_FETCH;
      default:    w_next = S_RST;
    endcase
  end

  // Moore outputs are registered alongside the state so they change with it
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_RST;
      r_ctrl  <= '0;
    end else begin
      r_state <= w_next;
      r_ctrl  <= moore_ctrl(w_next, opcode);
    end
  end

  assign w_fetch_ok = (r_state == S_FETCH) && mem_ready;
  assign w_br_take  = (r_state == S_BRANCH) && ((opcode == OP_BEQ) ? zero : !zero);

  assign pc_write   = r_ctrl.pc_write | w_fetch_ok | w_br_take;
  assign ir_write   = r_ctrl.ir_write | w_fetch_ok;
  assign pc_src     = r_ctrl.pc_src;
  assign mem_read   = r_ctrl.mem_read;
  assign mem_write  = r_ctrl.mem_write;
  assign iord       = r_ctrl.iord;
  assign reg_write  = r_ctrl.reg_write;
  assign reg_dst    = r_ctrl.reg_dst;
  assign mem_to_reg = r_ctrl.mem_to_reg;
  assign alu_src_a  = r_ctrl.alu_src_a;
  assign alu_src_b  = r_ctrl.alu_src_b;
  assign alu_op     = r_ctrl.alu_op;
  assign illegal_op = (r_state == S_DECODE) && opcode[3];
  assign bus_err    = w_expired;
  assign state_o    = r_state;

endmodule

// File: tb/tb_main_control_fsm.sv
// Directed table-driven bench for main_control_fsm plus hand sequences for timeout and reset.
// Latency: one vector per clock; inputs driven after posedge, outputs sampled at negedge.
// Backpressure: mem_ready is driven directly from the vectors.
module tb_main_control_fsm;

  logic       clk = 1'b0;
  logic       reset, zero, mem_ready;
  logic [3:0] opcode;
  logic       pc_write, ir_write, mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg;
  logic       alu_src_a, illegal_op, bus_err;
  logic [1:0] pc_src, alu_src_b, alu_op;
  logic [3:0] state_o;

  always #5 clk = ~clk;

  main_control_fsm #(.WAIT_MAX(16)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .mem_read(mem_read),
    .mem_write(mem_write), .iord(iord), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .illegal_op(illegal_op), .bus_err(bus_err), .state_o(state_o)
  );

  typedef struct packed {
    logic        rst;
    logic [3:0]  op;
    logic        z;
    logic        rdy;
    logic [3:0]  st;
    logic [16:0] o;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Expected output word: {pc_write, pc_src, ir_write, mem_read, mem_write, iord, reg_write,
  //                        reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, illegal_op, bus_err}
  function automatic logic [16:0] mk(int pcw, int pcs, int irw, int mr, int mw, int io, int rw,
                                     int rd, int m2r, int a, int b, int aop, int ill, int be);
    return {1'(pcw), 2'(pcs), 1'(irw), 1'(mr), 1'(mw), 1'(io), 1'(rw), 1'(rd), 1'(m2r),
            1'(a), 2'(b), 2'(aop), 1'(ill), 1'(be)};
  endfunction

  function automatic logic [16:0] actual();
    return {pc_write, pc_src, ir_write, mem_read, mem_write, iord, reg_write, reg_dst,
            mem_to_reg, alu_src_a, alu_src_b, alu_op, illegal_op, bus_err};
  endfunction

  task automatic add(input logic r, input logic [3:0] op, input logic z, input logic rdy,
                     input logic [3:0] st, input logic [16:0] o);
    vec_t v;
    v.rst = r; v.op = op; v.z = z; v.rdy = rdy; v.st = st; v.o = o;
    tbl.push_back(v);
  endtask

  // One clock: drive inputs, check state and outputs at negedge, advance past posedge
  task automatic cyc(input logic r, input logic [3:0] op, input logic z, input logic rdy,
                     input logic [3:0] st, input logic [16:0] o);
    logic [16:0] act;
    reset = r; opcode = op; zero = z; mem_ready = rdy;
    @(negedge clk);
    act = actual();
    n_vec++;
    if (state_o !== st || act !== o) begin
      n_bad++;
      $display("FAIL vec %0d: got state=%0d out=%05h, expected state=%0d out=%05h",
               n_vec, state_o, act, st, o);
    end
    @(posedge clk);
    #1;
  endtask

  logic [16:0] Z, FOK, FST, DEC, DILL, EXR, EXI_OR, EXI_ADD, WB_R, WB_I, MADDR;
  logic [16:0] MRD, MWB, MWR, MWR_BE, FST_BE, BR_T, BR_N, JMP;

  initial begin
    //          pcw pcs irw mr mw io rw rd m2r a  b  aop ill be
    Z       = '0;
    FOK     = mk(1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    FST     = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    FST_BE  = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    DEC     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0);
    DILL    = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 1, 0);
    EXR     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2, 0, 0);
    EXI_OR  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 3, 0, 0);
    EXI_ADD = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0);
    MADDR   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0);
    WB_R    = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    WB_I    = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    MRD     = mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    MWB     = mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    MWR     = mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    MWR_BE  = mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    BR_T    = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    BR_N    = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    JMP     = mk(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // reset (2 cycles) then R-type add
    add(1, 0, 0, 1, 0, Z);
    add(0, 0, 0, 1, 0, Z);
    add(0, 0, 0, 1, 1, FOK);
    add(0, 0, 0, 1, 2, DEC);
    add(0, 0, 0, 1, 3, EXR);
    add(0, 0, 0, 1, 5, WB_R);
    // ori
    add(0, 2, 0, 1, 1, FOK);
    add(0, 2, 0, 1, 2, DEC);
    add(0, 2, 0, 1, 4, EXI_OR);
    add(0, 2, 0, 1, 5, WB_I);
    // addi with one fetch stall
    add(0, 1, 0, 0, 1, FST);
    add(0, 1, 0, 1, 1, FOK);
    add(0, 1, 0, 1, 2, DEC);
    add(0, 1, 0, 1, 4, EXI_ADD);
    add(0, 1, 0, 1, 5, WB_I);
    // lw with three MEM_RD stalls
    add(0, 3, 0, 1, 1, FOK);
    add(0, 3, 0, 1, 2, DEC);
    add(0, 3, 0, 1, 6, MADDR);
    add(0, 3, 0, 0, 7, MRD);
    add(0, 3, 0, 0, 7, MRD);
    add(0, 3, 0, 0, 7, MRD);
    add(0, 3, 0, 1, 7, MRD);
    add(0, 3, 0, 1, 8, MWB);
    // sw
    add(0, 4, 0, 1, 1, FOK);
    add(0, 4, 0, 1, 2, DEC);
    add(0, 4, 0, 1, 6, MADDR);
    add(0, 4, 0, 1, 9, MWR);
    // beq zero=1 taken
    add(0, 5, 1, 1, 1, FOK);
    add(0, 5, 1, 1, 2, DEC);
    add(0, 5, 1, 1, 10, BR_T);
    // bne zero=1 not taken
    add(0, 6, 1, 1, 1, FOK);
    add(0, 6, 1, 1, 2, DEC);
    add(0, 6, 1, 1, 10, BR_N);
    // bne zero=0 taken
    add(0, 6, 0, 1, 1, FOK);
    add(0, 6, 0, 1, 2, DEC);
    add(0, 6, 0, 1, 10, BR_T);
    // jump
    add(0, 7, 0, 1, 1, FOK);
    add(0, 7, 0, 1, 2, DEC);
    add(0, 7, 0, 1, 11, JMP);
    // illegal opcode 12, then back in FETCH (stalled)
    add(0, 12, 0, 1, 1, FOK);
    add(0, 12, 0, 1, 2, DILL);
    add(0, 12, 0, 0, 1, FST);

    reset = 1'b1; opcode = '0; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk);
    #1;
    foreach (tbl[i]) cyc(tbl[i].rst, tbl[i].op, tbl[i].z, tbl[i].rdy, tbl[i].st, tbl[i].o);

    // sw whose write never completes: bus_err on the 16th stalled cycle, then FETCH
    cyc(0, 4, 0, 1, 1, FOK);
    cyc(0, 4, 0, 1, 2, DEC);
    cyc(0, 4, 0, 1, 6, MADDR);
    for (int i = 0; i < 15; i++) cyc(0, 4, 0, 0, 9, MWR);
    cyc(0, 4, 0, 0, 9, MWR_BE);

    // fetch timeout: stays in FETCH with the count restarted
    for (int i = 0; i < 15; i++) cyc(0, 4, 0, 0, 1, FST);
    cyc(0, 4, 0, 0, 1, FST_BE);
    cyc(0, 3, 0, 0, 1, FST);

    // mem_ready on the limit cycle wins over the timeout
    for (int i = 0; i < 14; i++) cyc(0, 3, 0, 0, 1, FST);
    cyc(0, 3, 0, 1, 1, FOK);
    cyc(0, 3, 0, 1, 2, DEC);
    cyc(0, 3, 0, 1, 6, MADDR);
    cyc(0, 3, 0, 0, 7, MRD);

    // reset during MEM_RD drops the read: RST next, no MEM_WB
    cyc(1, 3, 0, 1, 7, MRD);
    cyc(0, 3, 0, 1, 0, Z);
    cyc(0, 3, 0, 1, 1, FOK);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
